// File: rtl/uart_rx_stream.sv
// UART receiver (8N1; 8E1/8O1 when UART_RX_PARITY_EN is defined) into a FWFT byte FIFO.
// Stop-bit sample to o_tvalid is 2 clk; a stalled consumer fills the FIFO, then bytes drop with o_overflow.
module uart_rx_stream_fifo #(
  parameter int W  = 8,
  parameter int EA = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] mem [0:(1<<EA)-1];
  logic [EA:0]  wp, rp;
  logic         do_rd, do_wr;

  assign empty = (wp == rp);
  assign full  = (wp[EA] != rp[EA]) && (wp[EA-1:0] == rp[EA-1:0]);
  assign do_rd = rd & ~empty;
  // When full, the write slot is the slot being popped, so a same-cycle pop frees it.
  assign do_wr = wr & (~full | do_rd);
  assign rdata = empty ? '0 : mem[rp[EA-1:0]];

  always_ff @(posedge clk)
    if (do_wr) mem[wp[EA-1:0]] <= wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
    end
  end
endmodule

module uart_rx_stream #(
  parameter int    CLK_FREQ  = 50000000,
  parameter int    BAUD_RATE = 115200,
  parameter int    FIFO_EA   = 4,
  parameter string PARITY    = "NONE"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_uart_rx,
  input  logic       o_tready,
  output logic       o_tvalid,
  output logic [7:0] o_tdata,
  output logic       o_overflow,
  output logic       o_frame_err,
  output logic       o_parity_err
);
  localparam int CLK_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON  = (PARITY != "NONE");
  localparam bit PAR_ODD = (PARITY == "ODD");
`else
  localparam bit PAR_ON  = 1'b0 && (PARITY != "NONE");
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
`ifdef UART_RX_PARITY_EN
    , S_PAR
`endif
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          push;
  logic          rx_m, rx_s;
  logic          fifo_full, fifo_empty, pop;
`ifdef UART_RX_PARITY_EN
  logic          perr;
`else
  assign o_parity_err = PAR_ON;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) {rx_m, rx_s} <= 2'b11;
    else     {rx_m, rx_s} <= {i_uart_rx, rx_m};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      push        <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr         <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      push        <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
      cnt <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
          perr    <= 1'b0;
`endif
          if (!rx_s) state <= S_START;
        end
        S_START: if (cnt == HALF) begin
          cnt   <= '0;
          state <= rx_s ? S_IDLE : S_DATA;
        end
        S_DATA: if (cnt == LAST) begin
          cnt     <= '0;
          shreg   <= {rx_s, shreg[7:1]};
          bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= PAR_ON ? S_PAR : S_STOP;
`else
          if (bit_idx == 3'd7) state <= S_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        S_PAR: if (cnt == LAST) begin
          cnt   <= '0;
          perr  <= ((^shreg) ^ rx_s) != PAR_ODD;
          state <= S_STOP;
        end
`endif
        // Return to IDLE at mid-stop so a start bit right after one stop bit is caught.
        S_STOP: if (cnt == LAST) begin
          cnt <= '0;
          if (!rx_s) begin
            o_frame_err <= 1'b1;
            state       <= S_BREAK;
          end else begin
`ifdef UART_RX_PARITY_EN
            o_parity_err <= perr;
            push         <= ~perr;
`else
            push         <= 1'b1;
`endif
            state <= S_IDLE;
          end
        end
        S_BREAK: begin
          cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pop      = o_tvalid & o_tready;
  assign o_tvalid = ~fifo_empty;

  uart_rx_stream_fifo #(.W(8), .EA(FIFO_EA)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (push),
    .wdata (shreg),
    .rd    (pop),
    .rdata (o_tdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_overflow <= 1'b0;
    else     o_overflow <= push & fifo_full & ~pop;
  end
endmodule
